// File: rtl/peripheral_pkg.sv
// Shared constants for the peripheral hub: address prefixes, register selects
// and the PWM channel state encoding.
package peripheral_pkg;

    localparam logic [2:0] PFX_RAM = 3'b000;
    localparam logic [2:0] PFX_PWM = 3'b001;
    localparam logic [2:0] PFX_BTN = 3'b010;

    localparam logic SEL_ON    = 1'b0;
    localparam logic SEL_OFF   = 1'b1;
    localparam logic SEL_COUNT = 1'b0;
    localparam logic SEL_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        PWM_IDLE = 2'd0,
        PWM_ON   = 2'd1,
        PWM_OFF  = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow on/off registers that load into the active pair at a
// period boundary, or immediately while the channel is idle.
module pwm_channel
    import peripheral_pkg::*;
#(
    parameter int unsigned PWM_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_wr_on,
    input  logic                 i_wr_off,
    input  logic [PWM_WIDTH-1:0] i_wdata,
    output logic [PWM_WIDTH-1:0] o_shadow_on,
    output logic [PWM_WIDTH-1:0] o_shadow_off,
    output logic                 o_pwm
);

    localparam logic [PWM_WIDTH-1:0] ONE = PWM_WIDTH'(1);

    pwm_state_t           r_state, w_state_nxt;
    logic [PWM_WIDTH-1:0] r_sh_on, r_sh_off;
    logic [PWM_WIDTH-1:0] r_on, r_off, r_cnt;
    logic [PWM_WIDTH-1:0] w_on_nxt, w_off_nxt, w_cnt_nxt;
    logic                 w_reload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= PWM_IDLE;
            r_on     <= '0;
            r_off    <= '0;
            r_cnt    <= '0;
            r_sh_on  <= '0;
            r_sh_off <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_on    <= w_on_nxt;
            r_off   <= w_off_nxt;
            r_cnt   <= w_cnt_nxt;
            if (i_wr_on)  r_sh_on  <= i_wdata;
            if (i_wr_off) r_sh_off <= i_wdata;
        end
    end

    // r_cnt counts 1..N within the current phase; off=0 wraps ON straight
    // back to a new period so the output stays high across the boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_on_nxt    = r_on;
        w_off_nxt   = r_off;
        w_cnt_nxt   = r_cnt;
        w_reload    = 1'b0;
        case (r_state)
            PWM_IDLE: w_reload = 1'b1;
            PWM_ON: begin
                if (r_cnt >= r_on) begin
                    if (r_off == '0) begin
                        w_reload = 1'b1;
                    end else begin
                        w_state_nxt = PWM_OFF;
                        w_cnt_nxt   = ONE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            PWM_OFF: begin
                if (r_cnt >= r_off) w_reload = 1'b1;
                else                w_cnt_nxt = r_cnt + ONE;
            end
            default: w_state_nxt = PWM_IDLE;
        endcase
        if (w_reload) begin
            w_on_nxt  = r_sh_on;
            w_off_nxt = r_sh_off;
            w_cnt_nxt = ONE;
            if (r_sh_on != '0)       w_state_nxt = PWM_ON;
            else if (r_sh_off != '0) w_state_nxt = PWM_OFF;
            else                     w_state_nxt = PWM_IDLE;
        end
    end

    assign o_pwm        = (r_state == PWM_ON);
    assign o_shadow_on  = r_sh_on;
    assign o_shadow_off = r_sh_off;

endmodule

// File: rtl/peripheral_hub.sv
// Memory-mapped hub: PWM channels at prefix 001, button counters at 010.
// Define PERIPH_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable cycles per button.
module peripheral_hub
    import peripheral_pkg::*;
#(
    parameter int unsigned NUM_PWM         = 2,
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned PWM_WIDTH       = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        data_in,
    input  logic               write_enable,
    input  logic               read_enable,
    input  logic [NUM_BTN-1:0] btn,
    output logic [31:0]        data_out,
    output logic               data_valid,
    output logic               addr_error,
    output logic [NUM_PWM-1:0] pwm_out
);

    logic [2:0]  w_prefix;
    logic [6:0]  w_idx;
    logic        w_sel;
    logic        w_pwm_hit, w_btn_hit, w_mapped, w_rd;
    logic [31:0] w_pwm_rdata, w_btn_rdata, w_rdata;
    logic [31:0] r_data_out;
    logic        r_data_valid, r_addr_error;

    assign w_prefix  = addr[31:29];
    assign w_idx     = addr[7:1];
    assign w_sel     = addr[0];
    assign w_pwm_hit = (w_prefix == PFX_PWM) && (32'(w_idx) < NUM_PWM);
    assign w_btn_hit = (w_prefix == PFX_BTN) && (32'(w_idx) < NUM_BTN);
    assign w_mapped  = (w_prefix == PFX_RAM) || w_pwm_hit || w_btn_hit;
    // A simultaneous write wins; the read half is dropped.
    assign w_rd      = read_enable && !write_enable;

    logic [PWM_WIDTH-1:0] w_sh_on  [NUM_PWM];
    logic [PWM_WIDTH-1:0] w_sh_off [NUM_PWM];

    for (genvar g = 0; g < NUM_PWM; g++) begin : g_pwm
        pwm_channel #(.PWM_WIDTH(PWM_WIDTH)) u_ch (
            .clk          (clk),
            .reset        (reset),
            .i_wr_on      (write_enable && w_pwm_hit && (w_idx == 7'(g)) && (w_sel == SEL_ON)),
            .i_wr_off     (write_enable && w_pwm_hit && (w_idx == 7'(g)) && (w_sel == SEL_OFF)),
            .i_wdata      (data_in[PWM_WIDTH-1:0]),
            .o_shadow_on  (w_sh_on[g]),
            .o_shadow_off (w_sh_off[g]),
            .o_pwm        (pwm_out[g])
        );
    end

    logic [NUM_BTN-1:0] r_sync1, r_sync2, r_level, w_level_nxt, w_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_level <= w_level_nxt;
        end
    end

`ifdef PERIPH_DEBOUNCE_EN
    logic [31:0] r_db_cnt [NUM_BTN];

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (reset || (r_sync2[i] == r_level[i]) || (r_db_cnt[i] >= 32'(DEBOUNCE_CYCLES - 1)))
                r_db_cnt[i] <= '0;
            else
                r_db_cnt[i] <= r_db_cnt[i] + 32'd1;
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if ((r_sync2[i] != r_level[i]) && (r_db_cnt[i] >= 32'(DEBOUNCE_CYCLES - 1)))
                w_level_nxt[i] = r_sync2[i];
        end
    end
`else
    assign w_level_nxt = r_sync2;
`endif

    assign w_rise = w_level_nxt & ~r_level;

    logic [31:0] w_cnt [NUM_BTN];

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        logic [31:0] r_cnt;
        logic        w_clr;

        assign w_clr = w_rd && w_btn_hit && (w_sel == SEL_COUNT) && (w_idx == 7'(g));

        // Only conditional updates: the counter holds its value otherwise.
        always_ff @(posedge clk) begin
            if (reset)
                r_cnt <= '0;
            else if (w_clr)
                r_cnt <= w_rise[g] ? 32'd1 : 32'd0;
            else if (w_rise[g] && (r_cnt != '1))
                r_cnt <= r_cnt + 32'd1;
        end

        assign w_cnt[g] = r_cnt;
    end

    always_comb begin
        w_pwm_rdata = '0;
        w_btn_rdata = '0;
        for (int unsigned i = 0; i < NUM_PWM; i++) begin
            if (w_idx == 7'(i))
                w_pwm_rdata = (w_sel == SEL_OFF) ? 32'(w_sh_off[i]) : 32'(w_sh_on[i]);
        end
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (w_idx == 7'(i))
                w_btn_rdata = (w_sel == SEL_LEVEL) ? {31'b0, r_level[i]} : w_cnt[i];
        end
    end

    assign w_rdata = w_pwm_hit ? w_pwm_rdata : w_btn_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_addr_error <= 1'b0;
        end else begin
            r_data_valid <= w_rd && (w_pwm_hit || w_btn_hit);
            r_addr_error <= (write_enable || read_enable) &&
                            (!w_mapped || (write_enable && read_enable));
            if (w_rd && (w_pwm_hit || w_btn_hit))
                r_data_out <= w_rdata;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign addr_error = r_addr_error;

endmodule

// File: tb/tb_peripheral_hub.sv
// Directed self-checking bench for peripheral_hub; expectations follow
// PERIPH_DEBOUNCE_EN when the macro is defined for the build.
module tb_peripheral_hub;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [1:0]  btn;
    logic [31:0] data_out;
    logic        data_valid;
    logic        addr_error;
    logic [1:0]  pwm_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    peripheral_hub #(
        .NUM_PWM(2),
        .NUM_BTN(2),
        .PWM_WIDTH(32),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .data_in      (data_in),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .btn          (btn),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .addr_error   (addr_error),
        .pwm_out      (pwm_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; data_in = d; write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        rd(a);
        chk({tag, "_valid"}, 32'(data_valid), 32'd1);
        chk(tag, data_out, exp);
    endtask

    task automatic wait_pwm(input int ch, input logic lvl, input string tag);
        int k;
        k = 0;
        while (pwm_out[ch] !== lvl && k < 40) begin
            tick();
            k++;
        end
        chk(tag, 32'(k < 40), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  pat10;
        logic [7:0]  pat8;
        logic [31:0] last_dout;
        logic [31:0] exp_bounce;

        reset = 1'b1; addr = '0; data_in = '0;
        write_enable = 1'b0; read_enable = 1'b0; btn = '0;
        repeat (3) tick();
        chk("rst_pwm",   32'(pwm_out),    32'd0);
        chk("rst_dout",  data_out,        32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_err",   32'(addr_error), 32'd0);
        reset = 1'b0;
        tick();

        // ch0 on=3 off=2
        wr(32'h2000_0000, 32'd3);
        wr(32'h2000_0001, 32'd2);
        wait_pwm(0, 1'b0, "sync_low");
        wait_pwm(0, 1'b1, "sync_high");
        pat10 = '0;
        for (int i = 0; i < 10; i++) begin
            pat10 = {pat10[8:0], pwm_out[0]};
            tick();
        end
        chk("pwm_3_2", 32'(pat10), 32'(10'b1110011100));

        // first cycle of a new ON phase: change on to 1
        pat8 = '0;
        for (int i = 0; i < 8; i++) begin
            pat8 = {pat8[6:0], pwm_out[0]};
            if (i == 0) begin
                addr = 32'h2000_0000; data_in = 32'd1; write_enable = 1'b1;
            end else begin
                write_enable = 1'b0;
            end
            tick();
        end
        chk("pwm_midon_update", 32'(pat8), 32'(8'b11100100));

        rd_chk("ch0_on_shadow",  32'h2000_0000, 32'd1);
        rd_chk("ch0_off_shadow", 32'h2000_0001, 32'd2);
        last_dout = 32'd2;
        chk("ch1_idle_low", 32'(pwm_out[1]), 32'd0);

        // unmapped / out-of-range accesses
        rd(32'h6000_0000);
        chk("bad_pfx_err",   32'(addr_error), 32'd1);
        chk("bad_pfx_valid", 32'(data_valid), 32'd0);
        chk("dout_hold",     data_out,        last_dout);
        tick();
        chk("err_one_cycle", 32'(addr_error), 32'd0);
        wr(32'h2000_0004, 32'd7);
        chk("bad_pwm_idx_err", 32'(addr_error), 32'd1);
        repeat (3) tick();
        chk("bad_pwm_idx_ch1", 32'(pwm_out[1]), 32'd0);
        rd(32'h4000_0004);
        chk("bad_btn_idx_err",   32'(addr_error), 32'd1);
        chk("bad_btn_idx_valid", 32'(data_valid), 32'd0);
        wr(32'h0000_0000, 32'd5);
        chk("ram_wr_err", 32'(addr_error), 32'd0);
        rd(32'h0000_0010);
        chk("ram_rd_err",   32'(addr_error), 32'd0);
        chk("ram_rd_valid", 32'(data_valid), 32'd0);

        // both strobes: write happens, addr_error pulses, no read
        addr = 32'h2000_0003; data_in = 32'd9;
        write_enable = 1'b1; read_enable = 1'b1;
        tick();
        write_enable = 1'b0; read_enable = 1'b0;
        chk("both_err",   32'(addr_error), 32'd1);
        chk("both_valid", 32'(data_valid), 32'd0);
        rd_chk("both_wrote_ch1_off", 32'h2000_0003, 32'd9);
        chk("ch1_on0_low", 32'(pwm_out[1]), 32'd0);

        // bouncing btn[1]
        btn[1] = 1'b1; tick();
        btn[1] = 1'b0; tick();
        btn[1] = 1'b1; repeat (10) tick();
        btn[1] = 1'b0; repeat (10) tick();
`ifdef PERIPH_DEBOUNCE_EN
        exp_bounce = 32'd1;
`else
        exp_bounce = 32'd2;
`endif
        rd_chk("btn1_count", 32'h4000_0002, exp_bounce);
        tick();
        chk("btn1_valid_drop", 32'(data_valid), 32'd0);
        rd_chk("btn1_reread", 32'h4000_0002, 32'd0);

`ifndef PERIPH_DEBOUNCE_EN
        // rising edge coinciding with a clearing read
        btn[1] = 1'b1; repeat (4) tick();
        btn[1] = 1'b0; repeat (4) tick();
        btn[1] = 1'b1;
        tick();
        tick();
        addr = 32'h4000_0002; read_enable = 1'b1;
        tick();
        read_enable = 1'b0;
        chk("clr_edge_old", data_out, 32'd1);
        tick();
        rd_chk("clr_edge_left1", 32'h4000_0002, 32'd1);
        btn[1] = 1'b0; repeat (4) tick();
`endif

        // level read and saturation on btn[0]
        btn[0] = 1'b1; repeat (12) tick();
        rd_chk("btn0_level", 32'h4000_0001, 32'd1);
        rd_chk("btn1_level", 32'h4000_0003, 32'd0);
        btn[0] = 1'b0; repeat (12) tick();
        rd_chk("btn0_count", 32'h4000_0000, 32'd1);
        force dut.g_btn[0].r_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.g_btn[0].r_cnt;
        btn[0] = 1'b1; repeat (12) tick();
        btn[0] = 1'b0; repeat (12) tick();
        rd_chk("btn0_saturate", 32'h4000_0000, 32'hFFFF_FFFF);

        // reset during ON of ch1
        wr(32'h2000_0002, 32'd5);
        wait_pwm(1, 1'b1, "ch1_on_start");
        tick();
        chk("ch1_on_running", 32'(pwm_out[1]), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_pwm",   32'(pwm_out),    32'd0);
        chk("midrst_valid", 32'(data_valid), 32'd0);
        chk("midrst_dout",  data_out,        32'd0);
        reset = 1'b0;
        tick();
        repeat (3) tick();
        chk("postrst_pwm", 32'(pwm_out), 32'd0);
        rd_chk("postrst_ch1_on", 32'h2000_0002, 32'd0);
        rd_chk("postrst_btn0",   32'h4000_0000, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
